// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with a sequenced full-array clear.
// Entry 0 may be hardwired to zero; same-cycle write-to-read forwarding is optional.
module regfile_2r1w #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic [ADDR_W-1:0]   w_clr_idx_nxt;
  logic                r_wr_drop;
  logic                w_wr_drop_nxt;
  logic                w_zero_rd;
  logic                w_wr_en;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // State register; reset forces a clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_wr_drop_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nxt   = CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      CLEAR: begin
        // clr_req is ignored here, so an in-flight clear never restarts.
        w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
        w_wr_drop_nxt = regwrite;
        if (r_clr_idx == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_zero_rd = (ZERO_REG != 0) && (rd == '0);
  assign w_wr_en   = (r_state == IDLE) && regwrite && !w_zero_rd;

  // Array update: clear sweep has priority; writes only land in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_wr_en) begin
        r_mem[rd] <= writedata;
      end
    end
  end

  always_comb begin
    if (r_state == CLEAR) begin
      A = '0;
    end else if ((ZERO_REG != 0) && (rs == '0)) begin
      A = '0;
    end else if ((BYPASS != 0) && w_wr_en && (rd == rs)) begin
      A = writedata;
    end else begin
      A = r_mem[rs];
    end
  end

  always_comb begin
    if (r_state == CLEAR) begin
      B = '0;
    end else if ((ZERO_REG != 0) && (rt == '0)) begin
      B = '0;
    end else if ((BYPASS != 0) && w_wr_en && (rd == rt)) begin
      B = writedata;
    end else begin
      B = r_mem[rt];
    end
  end

  assign busy    = (r_state == CLEAR);
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: a default instance plus a BYPASS=0 / ZERO_REG=0
// instance sharing the same stimulus.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic        clr_req;

  logic [31:0] a1, b1, a2, b2;
  logic        busy1, busy2, drop1, drop2;

  int n_tests;
  int n_fail;
  int cnt;

  regfile_2r1w u_dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .A(a1), .B(b1),
    .regwrite(regwrite), .rd(rd), .writedata(writedata),
    .clr_req(clr_req), .busy(busy1), .wr_drop(drop1)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .A(a2), .B(b2),
    .regwrite(regwrite), .rd(rd), .writedata(writedata),
    .clr_req(clr_req), .busy(busy2), .wr_drop(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ticks until busy drops; the bound keeps a stuck clear from hanging the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1; rs = '0; rt = '0; regwrite = 1'b0; rd = '0;
    writedata = '0; clr_req = 1'b0;

    // Reset held one cycle, then the clear sweep runs for DEPTH cycles
    tick();
    #1;
    chk("rst_busy", 32'(busy1), 32'd1);
    chk("rst_A", a1, 32'd0);
    chk("rst_B", b1, 32'd0);
    chk("rst_drop", 32'(drop1), 32'd0);
    rst = 1'b0;
    wait_idle(cnt);
    chk("rst_busy_cycles", 32'(cnt), 32'd32);
    chk("rst_busy2_low", 32'(busy2), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      rt = 5'(31 - i);
      #1;
      chk("post_rst_A", a1, 32'd0);
      chk("post_rst_B", b1, 32'd0);
      chk("post_rst_A_nb", a2, 32'd0);
    end

    // Write 0xDEADBEEF to r7 with same-cycle read
    rs = 5'd7; rt = 5'd0; regwrite = 1'b1; rd = 5'd7; writedata = 32'hDEADBEEF;
    #1;
    chk("byp_A", a1, 32'hDEADBEEF);
    chk("nobyp_A_old", a2, 32'd0);
    tick();
    regwrite = 1'b0;
    #1;
    chk("r7_A", a1, 32'hDEADBEEF);
    chk("r0_B", b1, 32'd0);
    chk("r7_A_nb", a2, 32'hDEADBEEF);
    chk("r7_drop", 32'(drop1), 32'd0);

    // Write to r0: discarded with ZERO_REG=1, stored with ZERO_REG=0
    rs = 5'd0; regwrite = 1'b1; rd = 5'd0; writedata = 32'h12345678;
    #1;
    chk("r0_wr_A", a1, 32'd0);
    chk("r0_wr_A_nb_old", a2, 32'd0);
    tick();
    regwrite = 1'b0;
    #1;
    chk("r0_A", a1, 32'd0);
    chk("r0_drop", 32'(drop1), 32'd0);
    chk("r0_A_nb", a2, 32'h12345678);

    // Overwrite r4 (0x11 then 9) with read on both ports in the write cycle
    regwrite = 1'b1; rd = 5'd4; writedata = 32'h11;
    tick();
    rs = 5'd4; rt = 5'd4; writedata = 32'd9;
    #1;
    chk("r4_byp_A", a1, 32'd9);
    chk("r4_byp_B", b1, 32'd9);
    chk("r4_nobyp_A", a2, 32'h11);
    chk("r4_nobyp_B", b2, 32'h11);
    tick();
    regwrite = 1'b0;
    #1;
    chk("r4_next_A", a1, 32'd9);
    chk("r4_next_A_nb", a2, 32'd9);

    // Clear request with a dropped write on the 2nd CLEAR cycle
    regwrite = 1'b1; rd = 5'd3; writedata = 32'hAA;
    tick();
    regwrite = 1'b0; rs = 5'd3; rt = 5'd7;
    #1;
    chk("r3_pre", a1, 32'hAA);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    chk("clr_busy", 32'(busy1), 32'd1);
    chk("clr_A_zero", a1, 32'd0);
    chk("clr_B_zero", b1, 32'd0);
    tick();
    regwrite = 1'b1; rd = 5'd3; writedata = 32'd5; clr_req = 1'b1;
    #1;
    chk("drop_before", 32'(drop1), 32'd0);
    tick();
    regwrite = 1'b0; clr_req = 1'b0;
    #1;
    chk("drop_pulse", 32'(drop1), 32'd1);
    chk("drop_pulse_nb", 32'(drop2), 32'd1);
    tick();
    chk("drop_end", 32'(drop1), 32'd0);
    wait_idle(cnt);
    chk("clr_remaining", 32'(cnt), 32'd29);
    #1;
    chk("r3_cleared", a1, 32'd0);
    chk("r7_cleared", b1, 32'd0);
    chk("r3_cleared_nb", a2, 32'd0);

    // Reset at clr_idx=20 restarts the sweep; reset also suppresses wr_drop
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (20) tick();
    chk("mid_busy", 32'(busy1), 32'd1);
    rst = 1'b1; regwrite = 1'b1; rd = 5'd9; writedata = 32'h77;
    tick();
    rst = 1'b0; regwrite = 1'b0;
    #1;
    chk("rst_drop_suppr", 32'(drop1), 32'd0);
    wait_idle(cnt);
    chk("restart_cycles", 32'(cnt), 32'd32);

    // Normal operation resumes after the restarted clear
    regwrite = 1'b1; rd = 5'd31; writedata = 32'hCAFEF00D; rs = 5'd9; rt = 5'd31;
    tick();
    regwrite = 1'b0;
    #1;
    chk("r9_zero", a1, 32'd0);
    chk("r31_B", b1, 32'hCAFEF00D);
    chk("final_busy", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width in bits of each register entry.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, same-cycle write-to-read forwarding is enabled.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port rs, input, ADDR_W: read port A address.
REQ-008 SHALL have port rt, input, ADDR_W: read port B address.
REQ-009 SHALL have port A, output, DATA_W: read port A data, combinational.
REQ-010 SHALL have port B, output, DATA_W: read port B data, combinational.
REQ-011 SHALL have port regwrite, input, 1: write enable.
REQ-012 SHALL have port rd, input, ADDR_W: write address.
REQ-013 SHALL have port writedata, input, DATA_W: write data.
REQ-014 SHALL have port clr_req, input, 1: request a full-array clear.
REQ-015 SHALL have port busy, output, 1: clear sequence in progress.
REQ-016 SHALL have port wr_drop, output, 1: one-cycle pulse flagging a write discarded because busy was high.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and CLEAR, plus an ADDR_W-bit clear index clr_idx.
REQ-018 In CLEAR, each rising edge SHALL write zero to entry clr_idx and increment clr_idx.
REQ-019 The edge that clears entry DEPTH-1 SHALL move the FSM to IDLE; clr_idx wraps to 0.
REQ-020 In IDLE, clr_req=1 at an edge SHALL move the FSM to CLEAR with clr_idx=0.
REQ-021 clr_req SHALL be ignored while in CLEAR; the sequence does not restart.
REQ-022 busy SHALL equal 1 exactly while the FSM is in CLEAR.
REQ-023 In IDLE, regwrite=1 SHALL write writedata to entry rd at the edge.
REQ-024 Exception to REQ-023: with ZERO_REG=1 and rd=0, the write SHALL be discarded silently; wr_drop stays 0.
REQ-025 In IDLE with regwrite=1 and clr_req=1 at the same edge, the write SHALL complete and CLEAR SHALL begin on that edge.
REQ-026 In CLEAR, regwrite=1 SHALL NOT modify the array.
REQ-027 After any edge at which REQ-026 applied, wr_drop SHALL be 1 for exactly the following cycle; otherwise 0.
REQ-028 A SHALL be 0 while busy=1.
REQ-029 A SHALL be 0 when ZERO_REG=1 and rs=0.
REQ-030 A SHALL equal writedata when BYPASS=1, in IDLE, regwrite=1, rd=rs and the REQ-024 exception does not apply.
REQ-031 Otherwise A SHALL equal entry rs; priority is REQ-028 > REQ-029 > REQ-030 > REQ-031.
REQ-032 B SHALL follow REQ-028 to REQ-031 identically, using rt in place of rs.
REQ-033 With BYPASS=0, a read of an address written in the same cycle SHALL return the old value; the new value is visible the next cycle.

Reset
REQ-034 rst=1 at an edge SHALL force CLEAR with clr_idx=0 and wr_drop=0, overriding clr_req and regwrite.
REQ-035 rst SHALL restart the clear from entry 0 when asserted mid-CLEAR.
REQ-036 After rst deasserts, busy SHALL stay 1 for exactly DEPTH cycles, then read 0; all entries read 0 afterwards.
REQ-037 busy SHALL read 1 and A/B SHALL read 0 during and after reset until the clear completes.

Verification
REQ-038 Hold rst 1 cycle, defaults -> busy high 32 cycles, then 0; reading every address on A and B returns 0.
REQ-039 IDLE: write 0xDEADBEEF to rd=7, next cycle rs=7, rt=0 -> A=0xDEADBEEF, B=0; same-cycle rs=7 with BYPASS=1 -> A=0xDEADBEEF during the write cycle.
REQ-040 Write 0x12345678 to rd=0 with ZERO_REG=1 -> A(rs=0)=0 next cycle, wr_drop=0.
REQ-041 Pulse clr_req, then regwrite=1, rd=3, writedata=5 on the 2nd CLEAR cycle -> wr_drop=1 for one cycle; entry 3 reads 0 after busy falls.
REQ-042 Assert rst when clr_idx=20 -> clear restarts at 0; busy falls exactly 32 cycles after rst deasserts.
REQ-043 BYPASS=0, write 9 to rd=4 with rs=4 in same cycle -> A=old value that cycle, A=9 the next cycle.
